rr_mux_4x1: RTL and testbench

- Four-lane round-robin collector that merges four independent valid/ready streams onto one output stream. It is the gather end of the 1-to-4 lane fan-out.
- Each accepted word is tagged with its source lane index (out_sel), so a downstream 1-to-4 demux can route it back.
- Output is registered. Arbitration is fair round-robin, and no lane can be starved.

---
 rtl/rr_mux_4x1.sv | 91 +++++++++
 tb/tb_rr_mux_4x1.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_4x1.sv
// rr_mux_4x1: four-lane round-robin collector onto one registered stream.
// Each output word carries the index of the lane it came from.
module rr_mux_4x1 #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  input  logic                out_ready
);

  logic [1:0]        r_ptr;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_sel;

  logic [7:0]        w_dbl;
  logic [3:0]        w_rot;
  logic [1:0]        w_off;
  logic              w_any;
  logic [1:0]        w_idx;
  logic              w_load_ok;
  logic [3:0]        w_gnt;
  logic              w_fire;

  // bit k of w_rot is lane (ptr+k) mod 4, so the lowest set bit wins
  assign w_dbl = {in_valid, in_valid};
  assign w_rot = w_dbl[r_ptr +: 4];

  // priority-encode the rotated request vector
  always_comb begin
    w_off = 2'd0;
    w_any = 1'b0;
    if (w_rot[0]) begin
      w_off = 2'd0;
      w_any = 1'b1;
    end else if (w_rot[1]) begin
      w_off = 2'd1;
      w_any = 1'b1;
    end else if (w_rot[2]) begin
      w_off = 2'd2;
      w_any = 1'b1;
    end else if (w_rot[3]) begin
      w_off = 2'd3;
      w_any = 1'b1;
    end
  end

  // out_ready reaches the grant only through load_ok
  assign w_idx     = r_ptr + w_off;
  assign w_load_ok = ~r_valid | out_ready;

  // one-hot grant, forced idle while reset is held
  always_comb begin
    w_gnt = 4'b0000;
    if (rst_n && w_load_ok && w_any) begin
      w_gnt = 4'b0001 << w_idx;
    end
  end

  // the granted lane is valid by construction, so grant means transfer
  assign w_fire   = |w_gnt;
  assign in_ready = w_gnt;

  // output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= 2'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'd0;
    end else if (w_fire) begin
      r_ptr   <= w_idx + 2'd1;
      r_valid <= 1'b1;
      r_data  <= in_data[w_idx*DATA_W +: DATA_W];
      r_sel   <= w_idx;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// tb_rr_mux_4x1: directed vector table plus a same-lane ordering run.
// in_ready is checked before each edge, registered outputs after it.
module tb_rr_mux_4x1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int checks;
  int failures;

  rr_mux_4x1 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_sel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic [3:0] v,
    input logic [31:0] d, input logic ordy,
    input logic [3:0] e_rdy, input logic e_ov,
    input logic [7:0] e_od, input logic [1:0] e_sel
  );
    vec_t t;
    t.rst = rst;
    t.v = v;
    t.d = d;
    t.ordy = ordy;
    t.e_rdy = e_rdy;
    t.e_ov = e_ov;
    t.e_od = e_od;
    t.e_sel = e_sel;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  localparam logic [31:0] ALL = 32'h40302010;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 4'b0;
    in_data = '0;
    out_ready = 1'b0;

    // reset held three cycles with every lane requesting
    repeat (3) vecs.push_back(mk(0, 4'hF, ALL, 1, 4'b0000, 0, 8'h00, 2'd0));
    // single transfer on lane 2, then drain
    vecs.push_back(mk(1, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2'd2));
    vecs.push_back(mk(1, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'hA5, 2'd2));
    // reset to bring ptr back to lane 0
    vecs.push_back(mk(0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h00, 2'd0));
    // fairness: all lanes valid, one word per cycle
    vecs.push_back(mk(1, 4'hF, ALL, 1, 4'b0001, 1, 8'h10, 2'd0));
    vecs.push_back(mk(1, 4'hF, ALL, 1, 4'b0010, 1, 8'h20, 2'd1));
    vecs.push_back(mk(1, 4'hF, ALL, 1, 4'b0100, 1, 8'h30, 2'd2));
    vecs.push_back(mk(1, 4'hF, ALL, 1, 4'b1000, 1, 8'h40, 2'd3));
    vecs.push_back(mk(1, 4'hF, ALL, 1, 4'b0001, 1, 8'h10, 2'd0));
    vecs.push_back(mk(1, 4'hF, ALL, 1, 4'b0010, 1, 8'h20, 2'd1));
    vecs.push_back(mk(1, 4'hF, ALL, 1, 4'b0100, 1, 8'h30, 2'd2));
    vecs.push_back(mk(1, 4'hF, ALL, 1, 4'b1000, 1, 8'h40, 2'd3));
    // wrap after lane 3: lanes 0 and 2 valid
    vecs.push_back(mk(1, 4'b0101, ALL, 1, 4'b0001, 1, 8'h10, 2'd0));
    vecs.push_back(mk(1, 4'b0101, ALL, 1, 4'b0100, 1, 8'h30, 2'd2));
    vecs.push_back(mk(1, 4'b0000, ALL, 1, 4'b0000, 0, 8'h30, 2'd2));
    // load 0x77 on lane 0 (ptr=3 searches 3,0)
    vecs.push_back(mk(1, 4'b0001, 32'h00000077, 0, 4'b0001, 1, 8'h77, 2'd0));
    // backpressure four cycles, lanes 1 and 3 waiting
    repeat (4)
      vecs.push_back(mk(1, 4'b1010, 32'h33001100, 0, 4'b0000, 1, 8'h77, 2'd0));
    // release: ptr=1 picks lane 1, then lane 3
    vecs.push_back(mk(1, 4'b1010, 32'h33001100, 1, 4'b0010, 1, 8'h11, 2'd1));
    vecs.push_back(mk(1, 4'b1000, 32'h33000000, 1, 4'b1000, 1, 8'h33, 2'd3));
    // stall with nothing pending
    vecs.push_back(mk(1, 4'b0000, 32'h0, 0, 4'b0000, 1, 8'h33, 2'd3));
    // drain and idle: ptr stays at 0
    vecs.push_back(mk(1, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h33, 2'd3));
    vecs.push_back(mk(1, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h33, 2'd3));
    vecs.push_back(mk(1, 4'hF, ALL, 1, 4'b0001, 1, 8'h10, 2'd0));
    // ptr=1: lane 0 only, load 0x55 from lane 0
    vecs.push_back(mk(1, 4'b0001, 32'h00000055, 1, 4'b0001, 1, 8'h55, 2'd0));
    // reset mid-stream discards the word
    vecs.push_back(mk(0, 4'hF, ALL, 0, 4'b0000, 0, 8'h00, 2'd0));
    // lane 0 regains priority over lane 1
    vecs.push_back(mk(1, 4'b0011, ALL, 1, 4'b0001, 1, 8'h10, 2'd0));

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst;
      in_valid = vecs[i].v;
      in_data = vecs[i].d;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      chk($sformatf("v%0d_out_sel", i), 32'(out_sel), 32'(vecs[i].e_sel));
    end

    // ptr=1 now; lane 1 streams three words back to back in order
    for (int k = 0; k < 3; k++) begin
      rst_n = 1'b1;
      in_valid = 4'b0010;
      in_data = {16'h0, 8'(8'hC0 + k), 8'h0};
      out_ready = 1'b1;
      #1;
      chk($sformatf("seq%0d_in_ready", k), 32'(in_ready), 32'h2);
      @(posedge clk);
      #1;
      chk($sformatf("seq%0d_out_valid", k), 32'(out_valid), 32'h1);
      chk($sformatf("seq%0d_out_data", k), 32'(out_data), 32'(8'hC0 + k));
      chk($sformatf("seq%0d_out_sel", k), 32'(out_sel), 32'h1);
    end
    in_valid = 4'b0000;
    @(posedge clk);
    #1;
    chk("seq_drain_valid", 32'(out_valid), 32'h0);
    chk("seq_drain_data", 32'(out_data), 32'hC2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
